basic_system_ocrom_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the single-port 2048x16 instruction on-chip RAM/ROM.
- Master 0 is the CPU instruction fetch port (read-only). Master 1 is the debug port (read/write; debug writes patch memory).
- Drives the memory's address, byteenable, chipselect, write, writedata, debugaccess and clken inputs.
- Returns registered read data with a fixed 2-cycle latency and Avalon-MM pipelined handshaking (waitrequest/readdatavalid).

---
 rtl/basic_system_ocrom_arbiter.sv | 125 ++++++++++++
 tb/tb_basic_system_ocrom_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/basic_system_ocrom_arbiter.sv
// Two-master arbiter/sequencer for the single-port instruction on-chip RAM/ROM.
// The CPU fetch port (m0) and the debug port (m1) share the memory; reads return with a fixed 2-cycle latency.
module basic_system_ocrom_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16,
   parameter int BE_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reset_req,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic [BE_W-1:0]   m1_byteenable,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              mem_debugaccess,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic              req0_s;
   logic              req1_s;
   logic              gnt0_s;
   logic              gnt1_s;
   logic              rd_gnt_s;
   logic              rr_ptr_r;
   logic              s1_valid_r;
   logic              s1_id_r;
   logic              m0_rdv_r;
   logic              m1_rdv_r;
   logic [DATA_W-1:0] m0_readdata_r;
   logic [DATA_W-1:0] m1_readdata_r;

   assign mem_clken        = ~reset_req;
   assign m0_readdata      = m0_readdata_r;
   assign m1_readdata      = m1_readdata_r;
   assign m0_readdatavalid = m0_rdv_r;
   assign m1_readdatavalid = m1_rdv_r;

   // Request decode and round-robin grant; a simultaneous read+write on m1 counts as a write.
   always_comb begin
      req0_s   = m0_read;
      req1_s   = m1_read | m1_write;
      gnt0_s   = 1'b0;
      gnt1_s   = 1'b0;
      if (reset || reset_req) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (req0_s && req1_s) begin
         gnt0_s = ~rr_ptr_r;
         gnt1_s = rr_ptr_r;
      end else begin
         gnt0_s = req0_s;
         gnt1_s = req1_s;
      end
      rd_gnt_s       = gnt0_s | (gnt1_s & ~m1_write);
      m0_waitrequest = ~gnt0_s;
      m1_waitrequest = ~gnt1_s;
   end

   // Steer the granted master's command onto the memory port.
   always_comb begin
      mem_address     = '0;
      mem_byteenable  = '0;
      mem_chipselect  = 1'b0;
      mem_write       = 1'b0;
      mem_debugaccess = 1'b0;
      mem_writedata   = m1_writedata;
      if (gnt0_s) begin
         mem_address    = m0_address;
         mem_byteenable = '1;
         mem_chipselect = 1'b1;
      end else if (gnt1_s) begin
         mem_address     = m1_address;
         mem_byteenable  = m1_byteenable;
         mem_chipselect  = 1'b1;
         mem_write       = m1_write;
         mem_debugaccess = m1_write;
      end else begin
         mem_chipselect = 1'b0;
      end
   end

   // Fairness pointer and read-tag pipeline: stage 1 tags the memory cycle, the response registers form stage 2.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r      <= 1'b0;
         s1_valid_r    <= 1'b0;
         s1_id_r       <= 1'b0;
         m0_rdv_r      <= 1'b0;
         m1_rdv_r      <= 1'b0;
         m0_readdata_r <= '0;
         m1_readdata_r <= '0;
      end else begin
         // Under contention the loser gets priority next; lone requests leave the pointer alone.
         if (req0_s && req1_s && (gnt0_s || gnt1_s)) begin
            rr_ptr_r <= gnt0_s;
         end
         s1_valid_r <= rd_gnt_s;
         s1_id_r    <= gnt1_s;
         m0_rdv_r   <= s1_valid_r & ~s1_id_r;
         m1_rdv_r   <= s1_valid_r & s1_id_r;
         if (s1_valid_r && !s1_id_r) begin
            m0_readdata_r <= mem_readdata;
         end
         if (s1_valid_r && s1_id_r) begin
            m1_readdata_r <= mem_readdata;
         end
      end
   end

endmodule

// File: tb/tb_basic_system_ocrom_arbiter.sv
// Randomized bench for basic_system_ocrom_arbiter: a behavioural memory drives mem_readdata and a
// transaction-level reference model predicts grants, wait states and read responses.
module tb_basic_system_ocrom_arbiter;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 16;
   localparam int BE_W   = 2;
   localparam int NCYC   = 8192;

   logic              clk = 1'b0;
   logic              reset;
   logic              reset_req;
   logic [ADDR_W-1:0] m0_address;
   logic              m0_read;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;
   logic [ADDR_W-1:0] m1_address;
   logic              m1_read;
   logic              m1_write;
   logic [DATA_W-1:0] m1_writedata;
   logic [BE_W-1:0]   m1_byteenable;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic              mem_debugaccess;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   basic_system_ocrom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
      .clk(clk), .reset(reset), .reset_req(reset_req),
      .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_debugaccess(mem_debugaccess), .mem_writedata(mem_writedata),
      .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] init_word(input int a);
      logic [31:0] h;
      h = 32'(a) * 32'h0000_9E37 ^ 32'h0000_5A5A;
      if (a == 5)  return 16'hA5C3;
      if (a == 16) return 16'hABCD;
      return h[15:0];
   endfunction

   // Behavioural single-port RAM with clock enable and byte enables.
   logic [DATA_W-1:0] ram [0:2047];
   logic              ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 2048; i++) ram[i] <= init_word(i);
         ram_loaded <= 1'b1;
      end else if (mem_clken) begin
         if (mem_chipselect && mem_write) begin
            if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
         end
         mem_readdata <= ram[mem_address];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
   endtask

   // Reference model state: shadow memory, fairness turn, response schedule per cycle.
   logic [DATA_W-1:0] ref_mem [0:2047];
   logic              sv0 [0:NCYC-1];
   logic              sv1 [0:NCYC-1];
   logic [DATA_W-1:0] sd0 [0:NCYC-1];
   logic [DATA_W-1:0] sd1 [0:NCYC-1];
   logic [DATA_W-1:0] last0, last1;
   int                turn;
   bit                armed = 1'b0;
   bit                model_init = 1'b0;

   // Predict and compare at the falling edge, then advance the model for the coming rising edge.
   always @(negedge clk) begin
      int  g;
      bit  r0, r1;
      logic [DATA_W-1:0] old;
      if (!model_init) begin
         for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
         for (int i = 0; i < NCYC; i++) begin
            sv0[i] = 1'b0; sv1[i] = 1'b0; sd0[i] = '0; sd1[i] = '0;
         end
         last0 = '0; last1 = '0; turn = 0;
         model_init = 1'b1;
      end
      if (armed && cyc < NCYC - 2) begin
         r0 = m0_read;
         r1 = m1_read || m1_write;
         if (reset || reset_req) g = -1;
         else if (r0 && r1)      g = turn;
         else if (r0)            g = 0;
         else if (r1)            g = 1;
         else                    g = -1;
         check_eq("m0_waitrequest", 32'(m0_waitrequest), 32'(g != 0));
         check_eq("m1_waitrequest", 32'(m1_waitrequest), 32'(g != 1));
         check_eq("mem_clken", 32'(mem_clken), 32'(!reset_req));
         check_eq("mem_chipselect", 32'(mem_chipselect), 32'(g >= 0));
         if (g == 0) begin
            check_eq("mem_address_m0", 32'(mem_address), 32'(m0_address));
            check_eq("mem_write_m0", 32'(mem_write), 32'd0);
         end else if (g == 1) begin
            check_eq("mem_address_m1", 32'(mem_address), 32'(m1_address));
            check_eq("mem_write_m1", 32'(mem_write), 32'(m1_write));
            check_eq("mem_debugaccess", 32'(mem_debugaccess), 32'(m1_write));
         end
         check_eq("m0_readdatavalid", 32'(m0_readdatavalid), 32'(sv0[cyc]));
         check_eq("m1_readdatavalid", 32'(m1_readdatavalid), 32'(sv1[cyc]));
         if (sv0[cyc]) last0 = sd0[cyc];
         if (sv1[cyc]) last1 = sd1[cyc];
         check_eq("m0_readdata", 32'(m0_readdata), 32'(last0));
         check_eq("m1_readdata", 32'(m1_readdata), 32'(last1));
         if (g == 0) begin
            sv0[cyc+2] = 1'b1;
            sd0[cyc+2] = ref_mem[m0_address];
         end else if (g == 1 && m1_write) begin
            old = ref_mem[m1_address];
            ref_mem[m1_address] = {m1_byteenable[1] ? m1_writedata[15:8] : old[15:8],
                                   m1_byteenable[0] ? m1_writedata[7:0]  : old[7:0]};
         end else if (g == 1) begin
            sv1[cyc+2] = 1'b1;
            sd1[cyc+2] = ref_mem[m1_address];
         end
         if (r0 && r1 && g >= 0) turn = 1 - g;
      end
      if (reset) begin
         turn = 0;
         sv0[cyc+1] = 1'b0; sv1[cyc+1] = 1'b0;
         last0 = '0; last1 = '0;
         armed = 1'b1;
      end
      cyc++;
   end

   task automatic step(input bit r0, input int a0, input bit r1, input bit w1, input int a1,
                       input logic [15:0] wd, input logic [1:0] be, input bit rreq, input bit rst);
      m0_read = r0;  m0_address = ADDR_W'(a0);
      m1_read = r1;  m1_write = w1; m1_address = ADDR_W'(a1);
      m1_writedata = wd; m1_byteenable = be;
      reset_req = rreq; reset = rst;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int op;
      step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b1);
      repeat (3) step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      // single fetch, then back-to-back fetches
      step(1'b1, 5, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      repeat (3) step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      repeat (3) step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      // debug low-byte write followed immediately by a fetch of the same word
      step(1'b0, 0, 1'b0, 1'b1, 16, 16'h12FF, 2'b01, 1'b0, 1'b0);
      step(1'b1, 16, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      repeat (3) step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      // contention from reset
      step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, i, 1'b1, 1'b0, 100 + i, 16'h0, 2'b11, 1'b0, 1'b0);
      // reset_req while m0 streams
      for (int i = 0; i < 8; i++) step(1'b1, 40 + i, 1'b0, 1'b0, 0, 16'h0, 2'b00, (i >= 3 && i < 6), 1'b0);
      // reset the cycle after a grant
      step(1'b1, 7, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b1);
      repeat (3) step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      // randomized traffic over a small address window to provoke read-after-write
      for (int i = 0; i < 2000; i++) begin
         op = $urandom_range(0, 3);
         step($urandom_range(0, 9) < 7, $urandom_range(0, 31),
              (op == 1 || op == 3), (op >= 2), $urandom_range(0, 31),
              16'($urandom), 2'($urandom_range(0, 3)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      end
      repeat (4) step(1'b0, 0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
